// File: rtl/wb_load_writer_pkg.sv
// Shared definitions for the write-back load writer.
// Load funct3 codes, FSM states, width defaults and write constants.
package wb_load_writer_pkg;

   localparam int XLEN_DEF       = 32;
   localparam int REG_ADDR_W_DEF = 5;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic WE_ON  = 1'b1;
   localparam logic WE_OFF = 1'b0;

   localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOAD = 1'b1
   } state_e;

   // Reserved codes fall into the default and behave as a word load.
   function automatic logic [2:0] bytes_needed(input logic [2:0] f3);
      logic [2:0] n;
      case (f3)
         F3_LB, F3_LBU: n = 3'd1;
         F3_LH, F3_LHU: n = 3'd2;
         default:       n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/wb_load_writer_extend.sv
// Combinational load extender: 4-byte buffer + funct3 -> XLEN word.
// Ports: byte_buf_i (assembled bytes), funct3_i, data_o (extended).
module load_extend
   import wb_load_writer_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [31:0]     byte_buf_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o
);

   always_comb begin
      data_o = XLEN'(byte_buf_i);
      case (funct3_i)
         F3_LB:   data_o = XLEN'($signed(byte_buf_i[7:0]));
         F3_LH:   data_o = XLEN'($signed(byte_buf_i[15:0]));
         F3_LBU:  data_o = XLEN'(byte_buf_i[7:0]);
         F3_LHU:  data_o = XLEN'(byte_buf_i[15:0]);
         default: data_o = XLEN'(byte_buf_i);
      endcase
   end

endmodule

// File: rtl/wb_load_writer.sv
// Write-back stage: drives the register file write port from ALU results
// or from loads assembled byte by byte off the memory interface.
// Ports: in_* (MEM-stage handshake), mem_byte* (load bytes),
//        stall_req (held while a load collects), we/waddr/wdata (RF port).
module wb_load_writer
   import wb_load_writer_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_wreg,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic                  in_is_load,
   input  logic [2:0]            in_funct3,
   input  logic [XLEN-1:0]       in_data,
   input  logic                  mem_byte_valid,
   input  logic [7:0]            mem_byte,
   output logic                  stall_req,
   output logic                  we,
   output logic [REG_ADDR_W-1:0] waddr,
   output logic [XLEN-1:0]       wdata
);

   state_e                state_q;
   logic [2:0]            count_q, count_d;
   logic [31:0]           buf_q, buf_d;
   logic [2:0]            f3_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic                  wreg_q;
   logic                  we_q;
   logic [REG_ADDR_W-1:0] waddr_q;
   logic [XLEN-1:0]       wdata_q;
   logic [XLEN-1:0]       ext_data;
   logic                  last_byte;

   // in_ready drops during reset so nothing is accepted while held.
   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign stall_req = (state_q == ST_LOAD);
   assign we        = we_q;
   assign waddr     = waddr_q;
   assign wdata     = wdata_q;

   // Extension sees the buffer including this cycle's byte, so the
   // final byte can be written the very next cycle.
   always_comb begin
      buf_d   = buf_q;
      count_d = count_q + 3'd1;
      if (mem_byte_valid)
         buf_d[{count_q[1:0], 3'b000} +: 8] = mem_byte;
      last_byte = (state_q == ST_LOAD) && mem_byte_valid &&
                  (count_d == bytes_needed(f3_q));
   end

   load_extend #(.XLEN(XLEN)) u_ext (
      .byte_buf_i (buf_d),
      .funct3_i   (f3_q),
      .data_o     (ext_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         buf_q   <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         wreg_q  <= 1'b0;
         we_q    <= WE_OFF;
         waddr_q <= '0;
         wdata_q <= XLEN'(ZERO_WORD);
      end else begin
         we_q <= WE_OFF;
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  if (in_is_load) begin
                     rd_q    <= in_rd;
                     wreg_q  <= in_wreg;
                     f3_q    <= in_funct3;
                     count_q <= '0;
                     buf_q   <= '0;
                     state_q <= ST_LOAD;
                  end else if (in_wreg && (|in_rd)) begin
                     we_q    <= WE_ON;
                     waddr_q <= in_rd;
                     wdata_q <= in_data;
                  end
               end
            end
            ST_LOAD: begin
               if (mem_byte_valid) begin
                  buf_q   <= buf_d;
                  count_q <= count_d;
               end
               if (last_byte) begin
                  state_q <= ST_IDLE;
                  // x0 loads drain their bytes but never write.
                  if (wreg_q && (|rd_q)) begin
                     we_q    <= WE_ON;
                     waddr_q <= rd_q;
                     wdata_q <= ext_data;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_load_writer.sv
// Self-checking bench for wb_load_writer.
// Table vectors, hand-written corner sequences and random ops vs a model.
module tb_wb_load_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_wreg;
   logic [4:0]  in_rd;
   logic        in_is_load;
   logic [2:0]  in_funct3;
   logic [31:0] in_data;
   logic        mem_byte_valid;
   logic [7:0]  mem_byte;
   logic        stall_req;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;

   int total  = 0;
   int passed = 0;

   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;

   always #5 clk = ~clk;

   wb_load_writer dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_wreg        (in_wreg),
      .in_rd          (in_rd),
      .in_is_load     (in_is_load),
      .in_funct3      (in_funct3),
      .in_data        (in_data),
      .mem_byte_valid (mem_byte_valid),
      .mem_byte       (mem_byte),
      .stall_req      (stall_req),
      .we             (we),
      .waddr          (waddr),
      .wdata          (wdata)
   );

   typedef struct {
      string       name;
      bit          ld;
      logic [2:0]  f3;
      bit          wr;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] bytes;
      int          gap;
      bit          exp_we;
      logic [31:0] exp_d;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   // Little-endian assembly, then two's-complement reinterpretation
   // for the signed byte/half loads.
   function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                            input logic [31:0] bytes);
      longint v;
      longint half;
      int n;
      logic [63:0] r;
      n = nbytes(f3);
      v = 0;
      for (int i = 0; i < n; i++)
         v += longint'(bytes[i*8 +: 8]) * (longint'(1) << (8 * i));
      half = longint'(1) << (8 * n - 1);
      if ((f3 == 3'b000 || f3 == 3'b001) && v >= half)
         v -= 2 * half;
      r = 64'(v);
      return r[31:0];
   endfunction

   task automatic run_op(input string nm, input bit ld,
                         input logic [2:0] f3, input bit wr,
                         input logic [4:0] rd, input logic [31:0] data,
                         input logic [31:0] bytes, input int gap,
                         input bit exp_we, input logic [31:0] exp_d);
      chk({nm, " ready"}, 32'(in_ready), 32'd1);
      in_valid   = 1'b1;
      in_is_load = ld;
      in_funct3  = f3;
      in_wreg    = wr;
      in_rd      = rd;
      in_data    = data;
      cyc();
      in_valid   = 1'b0;
      in_is_load = 1'b0;
      if (ld) begin
         for (int i = 0; i < nbytes(f3); i++) begin
            if (i > 0) begin
               repeat (gap) begin
                  chk({nm, " gap stall"}, 32'(stall_req), 32'd1);
                  cyc();
               end
            end
            chk({nm, " stall"}, 32'(stall_req), 32'd1);
            chk({nm, " busy"}, 32'(in_ready), 32'd0);
            chk({nm, " we idle"}, 32'(we), 32'd0);
            mem_byte_valid = 1'b1;
            mem_byte       = bytes[i*8 +: 8];
            cyc();
            mem_byte_valid = 1'b0;
            mem_byte       = 8'($urandom);
         end
      end
      if (exp_we) begin
         m_addr = rd;
         m_data = exp_d;
      end
      chk({nm, " we"}, 32'(we), 32'(exp_we));
      chk({nm, " waddr"}, 32'(waddr), 32'(m_addr));
      chk({nm, " wdata"}, wdata, m_data);
      chk({nm, " stall done"}, 32'(stall_req), 32'd0);
      chk({nm, " ready done"}, 32'(in_ready), 32'd1);
      cyc();
      chk({nm, " we after"}, 32'(we), 32'd0);
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{"alu", 0, 3'b000, 1, 5'd5, 32'hDEADBEEF, 0, 0, 1,
                  32'hDEADBEEF};
      vecs[1] = '{"lb", 1, 3'b000, 1, 5'd6, 0, 32'h80, 0, 1,
                  32'hFFFFFF80};
      vecs[2] = '{"lbu", 1, 3'b100, 1, 5'd6, 0, 32'h80, 0, 1,
                  32'h00000080};
      vecs[3] = '{"lh", 1, 3'b001, 1, 5'd3, 0, 32'h9234, 3, 1,
                  32'hFFFF9234};
      vecs[4] = '{"lhu", 1, 3'b101, 1, 5'd3, 0, 32'h9234, 3, 1,
                  32'h00009234};
      vecs[5] = '{"lw", 1, 3'b010, 1, 5'd8, 0, 32'h12345678, 1, 1,
                  32'h12345678};
      vecs[6] = '{"lw x0", 1, 3'b010, 1, 5'd0, 0, 32'hCAFEBABE, 0, 0,
                  32'h0};
      vecs[7] = '{"alu nowreg", 0, 3'b000, 0, 5'd9, 32'h55AA55AA, 0, 0, 0,
                  32'h0};
      vecs[8] = '{"rsvd f3", 1, 3'b111, 1, 5'd10, 0, 32'hAABBCCDD, 0, 1,
                  32'hAABBCCDD};
      vecs[9] = '{"lb pos", 1, 3'b000, 1, 5'd11, 0, 32'h7F, 2, 1,
                  32'h0000007F};

      rst            = 1'b1;
      in_valid       = 1'b0;
      in_wreg        = 1'b0;
      in_rd          = '0;
      in_is_load     = 1'b0;
      in_funct3      = '0;
      in_data        = '0;
      mem_byte_valid = 1'b0;
      mem_byte       = '0;
      #1;
      chk("rst ready", 32'(in_ready), 32'd0);
      chk("rst we", 32'(we), 32'd0);
      chk("rst waddr", 32'(waddr), 32'd0);
      chk("rst wdata", wdata, 32'd0);
      chk("rst stall", 32'(stall_req), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("post rst ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 10; i++)
         run_op(vecs[i].name, vecs[i].ld, vecs[i].f3, vecs[i].wr,
                vecs[i].rd, vecs[i].data, vecs[i].bytes, vecs[i].gap,
                vecs[i].exp_we, vecs[i].exp_d);

      // LW with an ALU op waiting; it is taken as the load writes.
      in_valid   = 1'b1;
      in_is_load = 1'b1;
      in_funct3  = 3'b010;
      in_wreg    = 1'b1;
      in_rd      = 5'd12;
      cyc();
      in_is_load = 1'b0;
      in_rd      = 5'd13;
      in_data    = 32'hCAFEF00D;
      for (int i = 0; i < 4; i++) begin
         chk("lw+alu busy", 32'(in_ready), 32'd0);
         mem_byte_valid = 1'b1;
         mem_byte       = 8'(8'h78 - 8'(i * 8'h22));
         cyc();
      end
      mem_byte_valid = 1'b0;
      chk("lw+alu we1", 32'(we), 32'd1);
      chk("lw+alu waddr1", 32'(waddr), 32'd12);
      chk("lw+alu wdata1", wdata, 32'h12345678);
      chk("lw+alu ready", 32'(in_ready), 32'd1);
      cyc();
      in_valid = 1'b0;
      chk("lw+alu we2", 32'(we), 32'd1);
      chk("lw+alu waddr2", 32'(waddr), 32'd13);
      chk("lw+alu wdata2", wdata, 32'hCAFEF00D);
      cyc();
      chk("lw+alu we off", 32'(we), 32'd0);

      // Back-to-back ALU ops with stray byte pulses in IDLE.
      mem_byte_valid = 1'b1;
      mem_byte       = 8'hFF;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1;
         in_wreg  = 1'b1;
         in_rd    = 5'(i);
         in_data  = 32'(i) * 32'h111;
         cyc();
         chk("b2b we", 32'(we), 32'd1);
         chk("b2b waddr", 32'(waddr), 32'(i));
         chk("b2b wdata", wdata, 32'(i) * 32'h111);
      end
      in_valid = 1'b0;
      cyc();
      chk("stray we", 32'(we), 32'd0);
      chk("stray stall", 32'(stall_req), 32'd0);
      chk("stray ready", 32'(in_ready), 32'd1);
      mem_byte_valid = 1'b0;
      m_addr = 5'd4;
      m_data = 32'h444;
      run_op("lb after stray", 1, 3'b000, 1, 5'd20, 0, 32'h01, 0, 1,
             32'h00000001);

      // Reset two bytes into a word load.
      in_valid   = 1'b1;
      in_is_load = 1'b1;
      in_funct3  = 3'b010;
      in_rd      = 5'd14;
      cyc();
      in_valid   = 1'b0;
      in_is_load = 1'b0;
      mem_byte_valid = 1'b1;
      mem_byte       = 8'hAA;
      cyc();
      cyc();
      mem_byte_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst we", 32'(we), 32'd0);
      chk("midrst waddr", 32'(waddr), 32'd0);
      chk("midrst wdata", wdata, 32'd0);
      chk("midrst stall", 32'(stall_req), 32'd0);
      chk("midrst ready", 32'(in_ready), 32'd0);
      cyc();
      rst = 1'b0;
      #1;
      m_addr = '0;
      m_data = '0;
      run_op("lw fresh", 1, 3'b010, 1, 5'd15, 0, 32'h04030201, 0, 1,
             32'h04030201);

      // Random ops against the reference model.
      for (int k = 0; k < 40; k++) begin
         bit          ld;
         bit          wr;
         logic [2:0]  f3;
         logic [4:0]  rd;
         logic [31:0] d;
         logic [31:0] b;
         ld = 1'($urandom);
         wr = 1'($urandom);
         f3 = 3'($urandom);
         rd = 5'($urandom);
         d  = $urandom;
         b  = $urandom;
         run_op("rand", ld, f3, wr, rd, d, b, int'($urandom_range(0, 2)),
                wr && (rd != 0), ld ? ref_load(f3, b) : d);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
